// File: rtl/traffic_ctrl_param.sv
// Highway/farm-road lamp controller: timed Moore FSM with min/max greens, all-red clearance, night flash.
// Latency: lamps decode straight from registered state/phase, one edge from a qualifying input.
// Backpressure: none; the car sensor is sampled every cycle and never latched.
module traffic_ctrl_param #(
    parameter int HL_MIN_GREEN = 16,
    parameter int FL_MIN_GREEN = 4,
    parameter int FL_MAX_GREEN = 12,
    parameter int YELLOW_TIME  = 3,
    parameter int ALL_RED_TIME = 1,
    parameter int FLASH_HALF   = 2,
    parameter int CNT_W        = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       c,
    input  logic       night,
    output logic       HL_GREEN,
    output logic       HL_YELLOW,
    output logic       HL_RED,
    output logic       FL_GREEN,
    output logic       FL_YELLOW,
    output logic       FL_RED,
    output logic [2:0] state
);

    localparam logic [2:0] ST_HG    = 3'd0;
    localparam logic [2:0] ST_HY    = 3'd1;
    localparam logic [2:0] ST_AR1   = 3'd2;
    localparam logic [2:0] ST_FG    = 3'd3;
    localparam logic [2:0] ST_FY    = 3'd4;
    localparam logic [2:0] ST_AR2   = 3'd5;
    localparam logic [2:0] ST_FLASH = 3'd6;

    // Phase durations are compared against the last timer value of the phase.
    localparam logic [CNT_W-1:0] HL_MIN_M1 = CNT_W'(HL_MIN_GREEN - 1);
    localparam logic [CNT_W-1:0] FL_MIN_M1 = CNT_W'(FL_MIN_GREEN - 1);
    localparam logic [CNT_W-1:0] FL_MAX_M1 = CNT_W'(FL_MAX_GREEN - 1);
    localparam logic [CNT_W-1:0] YEL_M1    = CNT_W'(YELLOW_TIME - 1);
    localparam logic [CNT_W-1:0] AR_M1     = CNT_W'(ALL_RED_TIME - 1);
    localparam logic [CNT_W-1:0] FLASH_M1  = CNT_W'(FLASH_HALF - 1);
    localparam logic [CNT_W-1:0] TMR_SAT   = {CNT_W{1'b1}};

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic             phase_q, phase_d;
    logic             tmr_clr;

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        tmr_clr = 1'b0;
        case (state_q)
            ST_HG: begin
                // Night request wins over a waiting car and ignores the minimum green.
                if (night) begin
                    state_d = ST_FLASH;
                    phase_d = 1'b1;
                end else if (c && (timer_q >= HL_MIN_M1)) begin
                    state_d = ST_HY;
                end
            end
            ST_HY:  if (timer_q == YEL_M1) state_d = ST_AR1;
            ST_AR1: if (timer_q == AR_M1)  state_d = ST_FG;
            ST_FG: begin
                if ((timer_q == FL_MAX_M1) || (!c && (timer_q >= FL_MIN_M1))) begin
                    state_d = ST_FY;
                end
            end
            ST_FY:  if (timer_q == YEL_M1) state_d = ST_AR2;
            ST_AR2: if (timer_q == AR_M1)  state_d = ST_HG;
            ST_FLASH: begin
                // Leaving flash takes precedence over a phase toggle due on the same edge.
                if (!night) begin
                    state_d = ST_AR2;
                end else if (timer_q == FLASH_M1) begin
                    phase_d = ~phase_q;
                    tmr_clr = 1'b1;
                end
            end
            default: state_d = ST_HG;
        endcase

        if (tmr_clr || (state_d != state_q)) begin
            timer_d = '0;
        end else if (timer_q == TMR_SAT) begin
            timer_d = timer_q;
        end else begin
            timer_d = timer_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_HG;
            timer_q <= '0;
            phase_q <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            phase_q <= phase_d;
        end
    end

    always_comb begin
        HL_GREEN  = 1'b0;
        HL_YELLOW = 1'b0;
        HL_RED    = 1'b0;
        FL_GREEN  = 1'b0;
        FL_YELLOW = 1'b0;
        FL_RED    = 1'b0;
        case (state_q)
            ST_HG: begin
                HL_GREEN = 1'b1;
                FL_RED   = 1'b1;
            end
            ST_HY: begin
                HL_YELLOW = 1'b1;
                FL_RED    = 1'b1;
            end
            ST_AR1, ST_AR2: begin
                HL_RED = 1'b1;
                FL_RED = 1'b1;
            end
            ST_FG: begin
                HL_RED   = 1'b1;
                FL_GREEN = 1'b1;
            end
            ST_FY: begin
                HL_RED    = 1'b1;
                FL_YELLOW = 1'b1;
            end
            ST_FLASH: begin
                HL_YELLOW = phase_q;
                FL_RED    = phase_q;
            end
            default: begin
                // Unreachable code: hold both roads at red for the single cycle before HG.
                HL_RED = 1'b1;
                FL_RED = 1'b1;
            end
        endcase
    end

    assign state = state_q;

endmodule

// File: tb/tb_traffic_ctrl_param.sv
// Directed bench for traffic_ctrl_param: default instance plus a short-timing override instance.
module tb_traffic_ctrl_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, c, night;
    logic hl_g, hl_y, hl_r, fl_g, fl_y, fl_r;
    logic [2:0] st;

    logic rst2, c2, night2;
    logic hl_g2, hl_y2, hl_r2, fl_g2, fl_y2, fl_r2;
    logic [2:0] st2;

    int n_cmp = 0;
    int n_fail = 0;
    int conflicts = 0;

    localparam logic [5:0] L_HG = 6'b100001;
    localparam logic [5:0] L_HY = 6'b010001;
    localparam logic [5:0] L_AR = 6'b001001;
    localparam logic [5:0] L_FG = 6'b001100;
    localparam logic [5:0] L_FY = 6'b001010;

    traffic_ctrl_param u_dut (
        .clk(clk), .rst(rst), .c(c), .night(night),
        .HL_GREEN(hl_g), .HL_YELLOW(hl_y), .HL_RED(hl_r),
        .FL_GREEN(fl_g), .FL_YELLOW(fl_y), .FL_RED(fl_r),
        .state(st)
    );

    traffic_ctrl_param #(
        .YELLOW_TIME(1), .FL_MIN_GREEN(2), .FL_MAX_GREEN(2), .ALL_RED_TIME(2)
    ) u_dut2 (
        .clk(clk), .rst(rst2), .c(c2), .night(night2),
        .HL_GREEN(hl_g2), .HL_YELLOW(hl_y2), .HL_RED(hl_r2),
        .FL_GREEN(fl_g2), .FL_YELLOW(fl_y2), .FL_RED(fl_r2),
        .state(st2)
    );

    function automatic logic [5:0] lamps1();
        return {hl_g, hl_y, hl_r, fl_g, fl_y, fl_r};
    endfunction

    function automatic logic [5:0] lamps2();
        return {hl_g2, hl_y2, hl_r2, fl_g2, fl_y2, fl_r2};
    endfunction

    // Counts cycles spent in state s, starting from the current negedge; bounded.
    task automatic measure(input bit which, input logic [2:0] s, output int n);
        n = 0;
        while ((((which ? st2 : st) == s)) && (n < 200)) begin
            if (which && ((hl_g2 | hl_y2) && (fl_g2 | fl_y2))) conflicts++;
            n++;
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        c = 1'b0;
        night = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        n_cmp++;
        if (lamps1() !== L_HG || st !== 3'd0) begin
            n_fail++; $display("FAIL reset_async got lamps=%b st=%0d want lamps=%b st=0", lamps1(), st, L_HG);
        end
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (lamps1() !== L_HG || st !== 3'd0) begin
            n_fail++; $display("FAIL reset_held got lamps=%b st=%0d want lamps=%b st=0", lamps1(), st, L_HG);
        end
    endtask

    task automatic test_idle();
        do_reset();
        for (int i = 0; i < 100; i++) begin
            n_cmp++;
            if (lamps1() !== L_HG || st !== 3'd0) begin
                n_fail++; $display("FAIL idle_cyc%0d got lamps=%b st=%0d want lamps=%b st=0", i, lamps1(), st, L_HG);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_normal();
        logic [2:0] sq [3] = '{3'd0, 3'd1, 3'd2};
        int         ln [3] = '{16, 3, 1};
        logic [5:0] lp [3] = '{L_HG, L_HY, L_AR};
        int n;
        do_reset();
        c = 1'b1;
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (lamps1() !== lp[i]) begin
                n_fail++; $display("FAIL normal_lamps_s%0d got %b want %b", sq[i], lamps1(), lp[i]);
            end
            measure(1'b0, sq[i], n);
            n_cmp++;
            if (n !== ln[i]) begin
                n_fail++; $display("FAIL normal_len_s%0d got %0d want %0d", sq[i], n, ln[i]);
            end
        end
        n_cmp++;
        if (lamps1() !== L_FG || st !== 3'd3) begin
            n_fail++; $display("FAIL normal_fg_entry got lamps=%b st=%0d want lamps=%b st=3", lamps1(), st, L_FG);
        end
        @(negedge clk);
        c = 1'b0;
        measure(1'b0, 3'd3, n);
        n_cmp++;
        if (n + 1 !== 4) begin
            n_fail++; $display("FAIL normal_fg_min got %0d want 4", n + 1);
        end
        n_cmp++;
        if (lamps1() !== L_FY) begin
            n_fail++; $display("FAIL normal_fy_lamps got %b want %b", lamps1(), L_FY);
        end
        measure(1'b0, 3'd4, n);
        n_cmp++;
        if (n !== 3) begin
            n_fail++; $display("FAIL normal_fy_len got %0d want 3", n);
        end
        measure(1'b0, 3'd5, n);
        n_cmp++;
        if (n !== 1 || st !== 3'd0 || lamps1() !== L_HG) begin
            n_fail++; $display("FAIL normal_ar2_to_hg got len=%0d st=%0d lamps=%b want len=1 st=0 lamps=%b", n, st, lamps1(), L_HG);
        end
    endtask

    task automatic test_max_green();
        logic [2:0] sq [7] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0};
        int         ln [7] = '{16, 3, 1, 12, 3, 1, 16};
        logic [5:0] lp [7] = '{L_HG, L_HY, L_AR, L_FG, L_FY, L_AR, L_HG};
        int n;
        do_reset();
        c = 1'b1;
        for (int i = 0; i < 7; i++) begin
            n_cmp++;
            if (lamps1() !== lp[i] || st !== sq[i]) begin
                n_fail++; $display("FAIL maxg_step%0d got lamps=%b st=%0d want lamps=%b st=%0d", i, lamps1(), st, lp[i], sq[i]);
            end
            measure(1'b0, sq[i], n);
            n_cmp++;
            if (n !== ln[i]) begin
                n_fail++; $display("FAIL maxg_len_step%0d got %0d want %0d", i, n, ln[i]);
            end
        end
        n_cmp++;
        if (st !== 3'd1) begin
            n_fail++; $display("FAIL maxg_second_hy got st=%0d want 1", st);
        end
    endtask

    task automatic test_priority();
        do_reset();
        repeat (20) @(negedge clk);
        c = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (st !== 3'd1 || hl_y !== 1'b1) begin
            n_fail++; $display("FAIL c_latency got st=%0d hl_y=%b want st=1 hl_y=1", st, hl_y);
        end
        do_reset();
        repeat (20) @(negedge clk);
        c = 1'b1;
        night = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (st !== 3'd6 || hl_y !== 1'b1 || fl_r !== 1'b1) begin
            n_fail++; $display("FAIL night_over_c got st=%0d hl_y=%b fl_r=%b want st=6 hl_y=1 fl_r=1", st, hl_y, fl_r);
        end
        night = 1'b0;
        c = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (st !== 3'd5) begin
            n_fail++; $display("FAIL flash_exit got st=%0d want 5", st);
        end
    endtask

    task automatic test_night();
        logic [2:0] sq [3] = '{3'd0, 3'd1, 3'd2};
        logic exp;
        int n;
        do_reset();
        c = 1'b1;
        for (int i = 0; i < 3; i++) measure(1'b0, sq[i], n);
        night = 1'b1;
        measure(1'b0, 3'd3, n);
        n_cmp++;
        if (n !== 12) begin
            n_fail++; $display("FAIL night_fg_len got %0d want 12", n);
        end
        measure(1'b0, 3'd4, n);
        n_cmp++;
        if (n !== 3) begin
            n_fail++; $display("FAIL night_fy_len got %0d want 3", n);
        end
        measure(1'b0, 3'd5, n);
        n_cmp++;
        if (n !== 1) begin
            n_fail++; $display("FAIL night_ar2_len got %0d want 1", n);
        end
        measure(1'b0, 3'd0, n);
        n_cmp++;
        if (n !== 1 || st !== 3'd6) begin
            n_fail++; $display("FAIL night_hg_to_flash got len=%0d st=%0d want len=1 st=6", n, st);
        end
        for (int k = 0; k < 8; k++) begin
            exp = ((k % 4) < 2);
            n_cmp++;
            if (st !== 3'd6 || lamps1() !== {1'b0, exp, 1'b0, 1'b0, 1'b0, exp}) begin
                n_fail++; $display("FAIL flash_cyc%0d got st=%0d lamps=%b want st=6 hl_y=fl_r=%b", k, st, lamps1(), exp);
            end
            if (k < 7) @(negedge clk);
        end
        night = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (st !== 3'd5 || lamps1() !== L_AR) begin
            n_fail++; $display("FAIL flash_exit_on_toggle got st=%0d lamps=%b want st=5 lamps=%b", st, lamps1(), L_AR);
        end
        measure(1'b0, 3'd5, n);
        n_cmp++;
        if (n !== 1 || st !== 3'd0) begin
            n_fail++; $display("FAIL flash_ar2_len got len=%0d st=%0d want len=1 st=0", n, st);
        end
    endtask

    task automatic test_reset_mid();
        logic [2:0] sq [4] = '{3'd0, 3'd1, 3'd2, 3'd3};
        int n;
        do_reset();
        c = 1'b1;
        for (int i = 0; i < 4; i++) measure(1'b0, sq[i], n);
        n_cmp++;
        if (st !== 3'd4) begin
            n_fail++; $display("FAIL rstmid_in_fy got st=%0d want 4", st);
        end
        #1 rst = 1'b1;
        #1;
        n_cmp++;
        if (lamps1() !== L_HG || st !== 3'd0) begin
            n_fail++; $display("FAIL rstmid_async got lamps=%b st=%0d want lamps=%b st=0", lamps1(), st, L_HG);
        end
        #1 rst = 1'b0;
        @(negedge clk);
        measure(1'b0, 3'd0, n);
        n_cmp++;
        if (n + 1 !== 16) begin
            n_fail++; $display("FAIL rstmid_hg_min got %0d want 16", n + 1);
        end
    endtask

    task automatic test_override();
        logic [2:0] sq [6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5};
        int         ln [6] = '{16, 1, 2, 2, 1, 2};
        logic [5:0] lp [6] = '{L_HG, L_HY, L_AR, L_FG, L_FY, L_AR};
        int n;
        c2 = 1'b1;
        night2 = 1'b0;
        @(negedge clk);
        rst2 = 1'b0;
        conflicts = 0;
        for (int i = 0; i < 6; i++) begin
            n_cmp++;
            if (lamps2() !== lp[i]) begin
                n_fail++; $display("FAIL ovr_lamps_s%0d got %b want %b", sq[i], lamps2(), lp[i]);
            end
            measure(1'b1, sq[i], n);
            n_cmp++;
            if (n !== ln[i]) begin
                n_fail++; $display("FAIL ovr_len_s%0d got %0d want %0d", sq[i], n, ln[i]);
            end
        end
        n_cmp++;
        if (st2 !== 3'd0 || conflicts !== 0) begin
            n_fail++; $display("FAIL ovr_end got st=%0d conflicts=%0d want st=0 conflicts=0", st2, conflicts);
        end
    endtask

    initial begin
        rst = 1'b1; c = 1'b0; night = 1'b0;
        rst2 = 1'b1; c2 = 1'b0; night2 = 1'b0;
        test_reset();
        test_idle();
        test_normal();
        test_max_green();
        test_priority();
        test_night();
        test_reset_mid();
        test_override();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/traffic_ctrl_param.md
# traffic_ctrl_param

Parametrised highway/farm-road traffic-light controller: a timed Moore FSM driving the highway (HL) and farm-road (FL) red/yellow/green lamps from the farm-road car sensor `c`. All phase durations are parameters. The block adds a minimum highway green, a farm green bounded by minimum and maximum times, all-red clearance intervals, and a night flashing mode. It is the top-level lamp controller of the intersection design.

## Interface
- HL_MIN_GREEN, 16: minimum highway-green cycles before the farm road is served
- FL_MIN_GREEN, 4: minimum farm-green cycles
- FL_MAX_GREEN, 12: maximum farm-green cycles, applied even while `c` stays high
- YELLOW_TIME, 3: yellow cycles, used on both roads
- ALL_RED_TIME, 1: all-red clearance cycles
- FLASH_HALF, 2: cycles per half-period in flash mode
- CNT_W, 8: phase-timer width
- Legal values: all parameters ≥1 and <2^CNT_W; FL_MIN_GREEN ≤ FL_MAX_GREEN

Ports:
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  reset, asynchronous, active-high
- c  in  1  farm-road car present
- night  in  1  night flashing-mode request
- HL_GREEN, HL_YELLOW, HL_RED  out  1 each  highway lamps
- FL_GREEN, FL_YELLOW, FL_RED  out  1 each  farm-road lamps
- state  out  3  current state code

## Operation
- State codes: HG=0, HY=1, AR1=2, FG=3, FY=4, AR2=5, FLASH=6. Code 7 is illegal and goes to HG on the next edge.
- Lamps are decoded from the `state` register and the flash-phase register only. The decode is pure Moore: no lamp output depends combinationally on an input.
  - HG: HL_GREEN and FL_RED.
  - HY: HL_YELLOW and FL_RED.
  - AR1 and AR2: HL_RED and FL_RED.
  - FG: HL_RED and FL_GREEN.
  - FY: HL_RED and FL_YELLOW.
  - FLASH: HL_YELLOW = phase and FL_RED = phase. All other lamps are 0.
- Exactly one lamp per road is lit in every state except FLASH.
- `timer` (CNT_W bits) clears to 0 on every state change and otherwise increments each cycle. It saturates at all-ones.
- Transitions, with conditions evaluated at the rising edge:
  - HG: if night=1, go to FLASH. This has priority and ignores the minimum green. Otherwise, if c=1 and timer ≥ HL_MIN_GREEN−1, go to HY.
  - HY: at timer = YELLOW_TIME−1, go to AR1.
  - AR1: at timer = ALL_RED_TIME−1, go to FG.
  - FG: if timer = FL_MAX_GREEN−1, or (c=0 and timer ≥ FL_MIN_GREEN−1), go to FY.
  - FY: at timer = YELLOW_TIME−1, go to AR2.
  - AR2: at timer = ALL_RED_TIME−1, go to HG.
  - FLASH: while night=1, toggle phase at timer = FLASH_HALF−1 and clear timer. When night=0, go to AR2.
- Night mode is honoured only in HG. A request raised in any other state lets the cycle finish back to HG, then enters FLASH.
- The flash phase is set to 1 on FLASH entry.
- `c` is sampled, not latched. A car that leaves during HG before the minimum green expires is not served.

## Timing
- Reset values: state=HG, timer=0, phase=0. Lamps: HL_GREEN=1, FL_RED=1, all others 0. Lamps take these values immediately on rst assertion, with no clock edge needed.
- Reset mid-sequence (any state, including FLASH) abandons the sequence. There is no yellow or all-red on reset.
- State occupancy in cycles:
  - HY and FY: exactly YELLOW_TIME.
  - AR1 and AR2: exactly ALL_RED_TIME.
  - FG: between FL_MIN_GREEN and FL_MAX_GREEN.
  - HG before service: at least HL_MIN_GREEN.
- Latency from `c` rising in HG (timer already ≥ HL_MIN_GREEN−1) to HL_YELLOW=1 is 1 edge.
- Simultaneous events:
  - night=1 and c=1 in HG: FLASH wins.
  - FL_MAX reached while c=1: leave FG.
  - FL_MAX reached and FL_MIN satisfied together: leave FG (single transition).
- A night deassert landing on the same edge as a phase toggle still goes to AR2. The toggle is discarded.

## Test plan
- Reset, then c=0 and night=0 for 100 cycles: state stays 0, HL_GREEN=1 and FL_RED=1 throughout, no other lamps.
- Defaults, c=1 from reset, c drops at FG cycle 2: HG 16 cycles, HY 3, AR1 1, FG 4 (minimum enforced), FY 3, AR2 1, then HG.
- c held at 1 continuously: FG lasts exactly 12 cycles. The next HG lasts 16 cycles before HY, despite c=1.
- night=1 asserted during FG: sequence completes FY→AR2→HG, HG for 1 cycle, then FLASH. HL_YELLOW and FL_RED toggle every 2 cycles starting at 1. After night=0: AR2 for 1 cycle, then HG.
- rst pulsed mid-FY (between clock edges): lamps become HL_GREEN=1 and FL_RED=1 before the next edge. After release, HG holds the full 16-cycle minimum.
- Override YELLOW_TIME=1, FL_MIN_GREEN=FL_MAX_GREEN=2, ALL_RED_TIME=2, with c=1: HY 1 cycle, AR1 2, FG 2, FY 1, AR2 2. No two green or yellow lamps are ever lit on both roads in the same cycle.
